// File: rtl/vxbar_pkg.sv
// Shared types and constants for the vector-core crossbar sequencer.
package vxbar_pkg;

  localparam int NUM_OUT = 20;
  localparam int NUM_IN  = 16;
  localparam int SEL_W   = 4;

  localparam int CFG_W  = NUM_OUT * (SEL_W + 1);
  localparam int MASK_W = NUM_OUT * NUM_IN;
  localparam int REP_W  = 4;

  // One output's routing choice: enable plus input select.
  typedef struct packed {
    logic             en;
    logic [SEL_W-1:0] sel;
  } route_sel_t;

  // Compressed route entry; element i occupies bits [5i+4:5i].
  typedef route_sel_t [NUM_OUT-1:0] route_entry_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/vxbar_sel_decode.sv
// Expands a compressed route entry into the one-hot-per-output crossbar mask.
module vxbar_sel_decode
  import vxbar_pkg::*;
(
  input  route_entry_t      entry,
  output logic [MASK_W-1:0] mask
);

  // Each enabled output sets exactly one bit within its NUM_IN-wide slice.
  always_comb begin
    // NOTE: the default assignment ahead of the loop keeps every mask bit driven on all paths, so no latch is inferred.
    mask = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (entry[i].en) begin
        mask[i*NUM_IN +: NUM_IN] = NUM_IN'(1) << entry[i].sel;
      end
    end
  end

endmodule

// File: rtl/vector_xbar_ctrl.sv
// Route-table sequencer for the vector-core crossbar: stores compressed route
// entries and replays a window of them as expanded bitmasks over valid/ready.
// Optional feature macro: VXBAR_CTRL_REPEAT_EN adds start_rep (window replays).
module vector_xbar_ctrl
  import vxbar_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PTR_W-1:0]  cfg_addr,
  input  logic [CFG_W-1:0]  cfg_wdata,
  input  logic              start,
  input  logic [PTR_W-1:0]  start_base,
  input  logic [PTR_W:0]    start_len,
`ifdef VXBAR_CTRL_REPEAT_EN
  input  logic [REP_W-1:0]  start_rep,
`endif
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mask_valid,
  input  logic              mask_ready,
  output logic [MASK_W-1:0] routing_bitmask,
  output logic [PTR_W-1:0]  mask_idx
);

  localparam logic [PTR_W:0] LEN_ONE = (PTR_W+1)'(1);

  route_entry_t       route_tab [DEPTH];
  state_t             state;
  logic [PTR_W-1:0]   base_q;
  logic [PTR_W:0]     len_q;
  logic [PTR_W:0]     remaining;
  logic [REP_W-1:0]   rep_q;
  logic [REP_W-1:0]   rep_in;
  logic [PTR_W-1:0]   rd_addr;
  logic [MASK_W-1:0]  rd_mask;

`ifdef VXBAR_CTRL_REPEAT_EN
  assign rep_in = start_rep;
`else
  assign rep_in = '0;
`endif

  // Route table: written from the control path in any state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the table is flop-based and must come out of reset with every output disabled, so it is cleared here rather than left uninitialised like a RAM.
    if (rst) begin
      for (int a = 0; a < DEPTH; a++) route_tab[a] <= '0;
    end else if (cfg_we) begin
      route_tab[cfg_addr] <= route_entry_t'(cfg_wdata);
    end
  end

  // Next entry to load: base on start or at a pass boundary, otherwise idx+1.
  always_comb begin
    rd_addr = start_base;
    if (state == RUN) begin
      rd_addr = (remaining == LEN_ONE) ? base_q : PTR_W'(mask_idx + 1'b1);
    end
  end

  vxbar_sel_decode u_decode (
    .entry (route_tab[rd_addr]),
    .mask  (rd_mask)
  );

  assign busy = (state == RUN);

  // Sequencer FSM with registered mask, index, valid and done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      base_q          <= '0;
      len_q           <= '0;
      remaining       <= '0;
      rep_q           <= '0;
      done            <= 1'b0;
      mask_valid      <= 1'b0;
      routing_bitmask <= '0;
      mask_idx        <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values regardless of statement order.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_len == '0) begin
              done <= 1'b1;
            end else begin
              state           <= RUN;
              base_q          <= start_base;
              len_q           <= start_len;
              remaining       <= start_len;
              rep_q           <= rep_in;
              mask_valid      <= 1'b1;
              routing_bitmask <= rd_mask;
              mask_idx        <= start_base;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state      <= IDLE;
            mask_valid <= 1'b0;
          end else if (mask_ready) begin
            if (remaining > LEN_ONE || rep_q != '0) begin
              if (remaining > LEN_ONE) begin
                remaining <= remaining - LEN_ONE;
              end else begin
                remaining <= len_q;
                rep_q     <= rep_q - 1'b1;
              end
              routing_bitmask <= rd_mask;
              mask_idx        <= rd_addr;
            end else begin
              state      <= IDLE;
              mask_valid <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_xbar_ctrl.sv
// Self-checking bench for vector_xbar_ctrl: table-driven sequences, scoreboard
// of expected masks, and hand-written stall/abort/reset corner cases.
module tb_vector_xbar_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we;
  logic [2:0]   cfg_addr;
  logic [99:0]  cfg_wdata;
  logic         start;
  logic [2:0]   start_base;
  logic [3:0]   start_len;
`ifdef VXBAR_CTRL_REPEAT_EN
  logic [3:0]   start_rep;
`endif
  logic         abort;
  logic         busy;
  logic         done;
  logic         mask_valid;
  logic         mask_ready;
  logic [319:0] routing_bitmask;
  logic [2:0]   mask_idx;

  vector_xbar_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_wdata       (cfg_wdata),
    .start           (start),
    .start_base      (start_base),
    .start_len       (start_len),
`ifdef VXBAR_CTRL_REPEAT_EN
    .start_rep       (start_rep),
`endif
    .abort           (abort),
    .busy            (busy),
    .done            (done),
    .mask_valid      (mask_valid),
    .mask_ready      (mask_ready),
    .routing_bitmask (routing_bitmask),
    .mask_idx        (mask_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   idx;
    logic [319:0] mask;
  } exp_t;

  typedef struct {
    logic [2:0] base;
    logic [3:0] len;
    int         exp_lat;
  } vec_t;

  exp_t        exp_q[$];
  logic [99:0] tab [8];
  int          n_checks = 0;
  int          n_errors = 0;
  int          hs_cnt = 0;
  int          valid_cycles = 0;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference expansion of a compressed entry.
  function automatic logic [319:0] model_mask(input logic [99:0] e);
    logic [319:0] m;
    m = '0;
    for (int i = 0; i < 20; i++) begin
      if (e[5*i+4]) m[16*i + int'(e[5*i +: 4])] = 1'b1;
    end
    return m;
  endfunction

  // Scoreboard consumer: every accepted beat pops one expected record.
  always @(negedge clk) begin
    if (!rst && mask_valid) valid_cycles++;
    if (!rst && mask_valid && mask_ready && !abort) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_beat: got idx %0d with no expected entry", mask_idx);
      end else begin
        exp_t it;
        it = exp_q.pop_front();
        check("sb_idx", 320'(mask_idx), 320'(it.idx));
        check("sb_mask", routing_bitmask, it.mask);
      end
    end
  end

  task automatic push_window(input logic [2:0] base, input logic [3:0] len, input int rep);
    for (int p = 0; p <= rep; p++) begin
      for (int k = 0; k < int'(len); k++) begin
        exp_t it;
        it.idx  = 3'(int'(base) + k);
        it.mask = model_mask(tab[it.idx]);
        exp_q.push_back(it);
      end
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [99:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    tab[a] = d;
  endtask

  // Launch one sequence with ready held high and check done timing and beat count.
  task automatic run_seq(input logic [2:0] base, input logic [3:0] len, input int rep,
                         input int exp_lat, input string tag);
    int lat, nd, v0;
    mask_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; start_base = base; start_len = len;
`ifdef VXBAR_CTRL_REPEAT_EN
    start_rep = 4'(rep);
`endif
    push_window(base, len, rep);
    v0 = valid_cycles;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; nd = 0;
    for (int c = 1; c <= exp_lat + 4; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (lat < 0) lat = c;
      end
    end
    #1;
    check({tag, "_done_lat"}, 320'(lat), 320'(exp_lat));
    check({tag, "_done_cnt"}, 320'(nd), 320'd1);
    check({tag, "_beats"}, 320'(valid_cycles - v0), 320'(int'(len) * (rep + 1)));
    check({tag, "_sb_drained"}, 320'(exp_q.size()), 320'd0);
    check({tag, "_busy_end"}, 320'(busy), 320'd0);
  endtask

  vec_t vecs[5];

  initial begin
    logic [99:0] d;
    int nd, h0;

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; start_base = '0; start_len = '0; abort = 1'b0; mask_ready = 1'b0;
`ifdef VXBAR_CTRL_REPEAT_EN
    start_rep = '0;
`endif
    for (int a = 0; a < 8; a++) tab[a] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 320'(busy), 320'd0);
    check("rst_done", 320'(done), 320'd0);
    check("rst_valid", 320'(mask_valid), 320'd0);
    check("rst_mask", routing_bitmask, 320'd0);
    check("rst_idx", 320'(mask_idx), 320'd0);

    // Entry 2: every output enabled, sel = i mod 16; other entries random.
    d = '0;
    for (int i = 0; i < 20; i++) d[5*i +: 5] = {1'b1, 4'(i % 16)};
    cfg_write(3'd2, d);
    for (int a = 0; a < 8; a++) begin
      if (a != 2) cfg_write(3'(a), {$urandom, $urandom, $urandom, $urandom});
    end

    vecs[0] = '{base: 3'd2, len: 4'd1, exp_lat: 2};
    vecs[1] = '{base: 3'd6, len: 4'd4, exp_lat: 5};
    vecs[2] = '{base: 3'd0, len: 4'd8, exp_lat: 9};
    vecs[3] = '{base: 3'd5, len: 4'd2, exp_lat: 3};
    vecs[4] = '{base: 3'd3, len: 4'd0, exp_lat: 1};
    for (int v = 0; v < 5; v++) begin
      run_seq(vecs[v].base, vecs[v].len, 0, vecs[v].exp_lat, $sformatf("vec%0d", v));
    end

    // Stall: ready low for 3 cycles on beat 2 of a len-3 window.
    h0 = hs_cnt;
    mask_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; start_base = 3'd0; start_len = 4'd3;
    push_window(3'd0, 4'd3, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    mask_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j == 3) begin
        @(posedge clk); #1;
        mask_ready = 1'b1;
      end
      @(negedge clk);
      check("stall_valid", 320'(mask_valid), 320'd1);
      check("stall_idx", 320'(mask_idx), 320'd1);
      check("stall_mask", routing_bitmask, model_mask(tab[1]));
      if (j < 2) @(posedge clk);
    end
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    #1;
    check("stall_handshakes", 320'(hs_cnt - h0), 320'd3);
    check("stall_done_cnt", 320'(nd), 320'd1);

    // Abort with a simultaneous handshake on beat 2 of len 5.
    mask_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; start_base = 3'd3; start_len = 4'd5;
    push_window(3'd3, 4'd5, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_valid", 320'(mask_valid), 320'd0);
    check("abort_busy", 320'(busy), 320'd0);
    nd = int'(done);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", 320'(nd), 320'd0);
    run_seq(3'd0, 4'd1, 0, 2, "post_abort");

    // Start while busy is ignored.
    mask_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; start_base = 3'd4; start_len = 4'd2;
    push_window(3'd4, 4'd2, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; start_base = 3'd0; start_len = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_start_idx", 320'(mask_idx), 320'd4);
    check("busy_start_mask", routing_bitmask, model_mask(tab[4]));
    mask_ready = 1'b1;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    #1;
    check("busy_start_done", 320'(nd), 320'd1);
    check("busy_start_drained", 320'(exp_q.size()), 320'd0);

    // Write and start on the same entry in the same cycle: old data is loaded.
    d = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    start = 1'b1; start_base = 3'd5; start_len = 4'd1;
    cfg_we = 1'b1; cfg_addr = 3'd5; cfg_wdata = d;
    push_window(3'd5, 4'd1, 0);
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    tab[5] = d;
    repeat (4) @(negedge clk);
    #1;
    check("rw_old_drained", 320'(exp_q.size()), 320'd0);
    run_seq(3'd5, 4'd1, 0, 2, "rw_new");

`ifdef VXBAR_CTRL_REPEAT_EN
    run_seq(3'd0, 4'd2, 2, 7, "repeat");
`endif

    // Reset mid-run: outputs clear at once and the table reads back disabled.
    mask_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; start_base = 3'd0; start_len = 4'd8;
    push_window(3'd0, 4'd8, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 320'(busy), 320'd0);
    check("mid_rst_done", 320'(done), 320'd0);
    check("mid_rst_valid", 320'(mask_valid), 320'd0);
    check("mid_rst_mask", routing_bitmask, 320'd0);
    check("mid_rst_idx", 320'(mask_idx), 320'd0);
    exp_q.delete();
    for (int a = 0; a < 8; a++) tab[a] = '0;
    @(negedge clk);
    rst = 1'b0;
    run_seq(3'd2, 4'd1, 0, 2, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
